// File: rtl/mem_arbiter_pkg.sv
// Shared types for the unified-memory arbiter: FSM states, grant encoding
// and default bus widths.
package mem_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 16;
    localparam int unsigned DATA_W_DEF = 16;

    typedef enum logic [2:0] {
        IDLE,
        SRV_D,
        SRV_I,
        ERR_D,
        ERR_I
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_D,
        GNT_I
    } gnt_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of requester, halt and memory-macro signals around the arbiter.
// The master modport is the arbiter's view; slave is the surrounding
// pipeline/memory side.
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
);

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_done;
    logic [DATA_W-1:0] if_rdata;
    logic              if_err;
    logic              if_stall;

    logic              dm_req;
    logic              dm_wr;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_done;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_err;
    logic              dm_stall;

    logic              halt;
    logic              halted;

    logic              mem_req;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        input  if_req, if_addr,
        output if_done, if_rdata, if_err, if_stall,
        input  dm_req, dm_wr, dm_addr, dm_wdata,
        output dm_done, dm_rdata, dm_err, dm_stall,
        input  halt,
        output halted,
        output mem_req, mem_wr, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        output if_req, if_addr,
        input  if_done, if_rdata, if_err, if_stall,
        output dm_req, dm_wr, dm_addr, dm_wdata,
        input  dm_done, dm_rdata, dm_err, dm_stall,
        output halt,
        input  halted,
        input  mem_req, mem_wr, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );

endinterface

// File: rtl/mem_arbiter_starve_ctr.sv
// Saturating count of consecutive data grants made while a fetch waits.
module arb_starve_ctr #(
    parameter int unsigned MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam logic [3:0] MAX_V = 4'(MAX);

    logic [3:0] cnt;

    // Clear has priority; increment stops at the limit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != MAX_V)) begin
            cnt <= cnt + 4'd1;
        end
    end

    assign at_max = (cnt == MAX_V);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch (IF) and data
// access (DM). Data wins ties unless IF has been starved STARVE_MAX times.
// Optional performance counters are enabled by defining ARB_PERF_CNT_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.master bus
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]   if_stall_cnt,
    output logic [31:0]   dm_stall_cnt,
    output logic [15:0]   starve_evt_cnt
`endif
);

    arb_state_t        state;
    gnt_t              gnt;
    logic              starve_at_max;
    logic              starve_inc;
    logic              starve_clr;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] dm_rdata_q;
    logic              halted_q;
    logic              srv_d_ack;
    logic              srv_i_ack;
    logic [ADDR_W-1:0] addr_sel;

    // IDLE-cycle arbitration between the two requesters.
    always_comb begin
        gnt = GNT_NONE;
        if ((state == IDLE) && !bus.halt) begin
            if (bus.dm_req && bus.if_req) begin
                gnt = starve_at_max ? GNT_I : GNT_D;
            end else if (bus.dm_req) begin
                gnt = GNT_D;
            end else if (bus.if_req) begin
                gnt = GNT_I;
            end
        end
    end

    assign starve_inc = (gnt == GNT_D) && bus.if_req;
    assign starve_clr = (gnt == GNT_I) || ((gnt == GNT_D) && !bus.if_req);

    arb_starve_ctr #(.MAX(STARVE_MAX)) u_starve (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (starve_inc),
        .clr    (starve_clr),
        .at_max (starve_at_max)
    );

    // Transaction sequencing plus the registered read-data and halted flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            halted_q   <= 1'b0;
        end else begin
            halted_q <= bus.halt && (state == IDLE);
            unique case (state)
                IDLE: begin
                    case (gnt)
                        GNT_D:   state <= bus.dm_addr[0] ? ERR_D : SRV_D;
                        GNT_I:   state <= bus.if_addr[0] ? ERR_I : SRV_I;
                        default: state <= IDLE;
                    endcase
                end
                SRV_D: begin
                    if (bus.mem_ack) begin
                        dm_rdata_q <= bus.mem_rdata;
                        state      <= IDLE;
                    end
                end
                SRV_I: begin
                    if (bus.mem_ack) begin
                        if_rdata_q <= bus.mem_rdata;
                        state      <= IDLE;
                    end
                end
                ERR_D, ERR_I: state <= IDLE;
                default:      state <= IDLE;
            endcase
        end
    end

    // Done must coincide with mem_ack, so it and the read data are decoded
    // from the state register and passed through combinationally in the
    // ack cycle; the registered copy holds the word afterwards.
    assign srv_d_ack = rst_n && (state == SRV_D) && bus.mem_ack;
    assign srv_i_ack = rst_n && (state == SRV_I) && bus.mem_ack;

    assign bus.dm_done  = srv_d_ack || (rst_n && (state == ERR_D));
    assign bus.if_done  = srv_i_ack || (rst_n && (state == ERR_I));
    assign bus.dm_err   = rst_n && (state == ERR_D);
    assign bus.if_err   = rst_n && (state == ERR_I);
    assign bus.dm_rdata = srv_d_ack ? bus.mem_rdata : dm_rdata_q;
    assign bus.if_rdata = srv_i_ack ? bus.mem_rdata : if_rdata_q;
    assign bus.dm_stall = bus.dm_req && !bus.dm_done;
    assign bus.if_stall = bus.if_req && !bus.if_done;
    assign bus.halted   = halted_q;

    // Memory side follows the granted requester's live inputs.
    always_comb begin
        addr_sel = '0;
        if (state == SRV_D) begin
            addr_sel = bus.dm_addr;
        end else if (state == SRV_I) begin
            addr_sel = bus.if_addr;
        end
    end

    assign bus.mem_req   = (state == SRV_D) || (state == SRV_I);
    assign bus.mem_wr    = (state == SRV_D) && bus.dm_wr;
    assign bus.mem_addr  = addr_sel;
    assign bus.mem_wdata = (state == SRV_D) ? bus.dm_wdata : '0;

`ifdef ARB_PERF_CNT_EN
    logic starve_evt;
    assign starve_evt = (gnt == GNT_I) && bus.dm_req;

    // Saturating stall-cycle and starvation-event counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            if_stall_cnt   <= '0;
            dm_stall_cnt   <= '0;
            starve_evt_cnt <= '0;
        end else begin
            if (bus.if_stall && (if_stall_cnt != '1)) begin
                if_stall_cnt <= if_stall_cnt + 32'd1;
            end
            if (bus.dm_stall && (dm_stall_cnt != '1)) begin
                dm_stall_cnt <= dm_stall_cnt + 32'd1;
            end
            if (starve_evt && (starve_evt_cnt != '1)) begin
                starve_evt_cnt <= starve_evt_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a memory responder, directed scenarios
// and a randomized mixed IF/DM phase checked against a reference memory.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int unsigned AW   = 16;
    localparam int unsigned DW   = 16;
    localparam int unsigned SMAX = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef ARB_PERF_CNT_EN
    logic [31:0] if_stall_cnt;
    logic [31:0] dm_stall_cnt;
    logic [15:0] starve_evt_cnt;
`endif

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef ARB_PERF_CNT_EN
        ,
        .if_stall_cnt   (if_stall_cnt),
        .dm_stall_cnt   (dm_stall_cnt),
        .starve_evt_cnt (starve_evt_cnt)
`endif
    );

    typedef struct {
        bit          err;
        bit          chk_data;
        logic [15:0] data;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    exp_t        exp_d[$];
    exp_t        exp_i[$];
    byte         done_log[$];
    logic [15:0] ref_mem  [int unsigned];
    logic [15:0] phys_mem [int unsigned];
    int          ack_delay  = -1;
    int unsigned mem_cycles = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] init_word(input logic [15:0] a);
        return a ^ 16'h5A3C;
    endfunction

    function automatic logic [15:0] ref_read(input logic [15:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_word(a);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Memory macro model: acks after ack_delay cycles (random 0..3 if < 0).
    task automatic responder();
        bit          busy = 1'b0;
        int unsigned wl = 0;
        bit          legit;
        forever begin
            @(posedge clk);
            #1;
            if (bus.mem_req) mem_cycles++;
            if (bus.mem_ack) begin
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = '0;
                busy          = 1'b0;
            end else if (bus.mem_req && rst_n) begin
                if (!busy) begin
                    busy = 1'b1;
                    wl   = (ack_delay < 0) ? $urandom_range(0, 3) : ack_delay;
                    legit = bus.mem_wr
                        ? (bus.dm_req && bus.dm_wr && bus.mem_addr == bus.dm_addr
                           && bus.mem_wdata == bus.dm_wdata)
                        : ((bus.if_req && bus.mem_addr == bus.if_addr)
                           || (bus.dm_req && !bus.dm_wr && bus.mem_addr == bus.dm_addr));
                    check("mem_addr_aligned", 32'(bus.mem_addr[0]), 0);
                    check("mem_matches_requester", 32'(legit), 1);
                end
                if (wl == 0) begin
                    if (bus.mem_wr) phys_mem[bus.mem_addr] = bus.mem_wdata;
                    else bus.mem_rdata = phys_mem.exists(bus.mem_addr)
                                         ? phys_mem[bus.mem_addr] : init_word(bus.mem_addr);
                    bus.mem_ack = 1'b1;
                end else begin
                    wl--;
                end
            end else begin
                busy = 1'b0;
            end
        end
    endtask

    // Pops the scoreboard whenever a done pulse is presented.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.dm_err && !bus.dm_done) check("dm_err_without_done", 1, 0);
            if (bus.if_err && !bus.if_done) check("if_err_without_done", 1, 0);
            if (bus.dm_done) begin
                done_log.push_back("D");
                if (exp_d.size() == 0) begin
                    check("dm_done_unexpected", 1, 0);
                end else begin
                    e = exp_d.pop_front();
                    check("dm_err", 32'(bus.dm_err), 32'(e.err));
                    if (e.chk_data) check("dm_rdata", 32'(bus.dm_rdata), 32'(e.data));
                end
            end
            if (bus.if_done) begin
                done_log.push_back("I");
                if (exp_i.size() == 0) begin
                    check("if_done_unexpected", 1, 0);
                end else begin
                    e = exp_i.pop_front();
                    check("if_err", 32'(bus.if_err), 32'(e.err));
                    if (e.chk_data) check("if_rdata", 32'(bus.if_rdata), 32'(e.data));
                end
            end
        end
    endtask

    task automatic wait_done(input bit is_d);
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (is_d ? bus.dm_done : bus.if_done) return;
        end
        check(is_d ? "dm_done_timeout" : "if_done_timeout", 0, 1);
    endtask

    task automatic dm_start(input bit wr, input logic [15:0] addr, input logic [15:0] wdata);
        exp_t e;
        bus.dm_req = 1'b1; bus.dm_wr = wr; bus.dm_addr = addr; bus.dm_wdata = wdata;
        e.err = addr[0];
        e.chk_data = !addr[0] && !wr;
        e.data = ref_read(addr);
        if (!addr[0] && wr) ref_mem[addr] = wdata;
        exp_d.push_back(e);
    endtask

    task automatic dm_finish();
        wait_done(1'b1);
        step();
        bus.dm_req = 1'b0;
    endtask

    task automatic dm_op(input bit wr, input logic [15:0] addr, input logic [15:0] wdata);
        dm_start(wr, addr, wdata);
        dm_finish();
    endtask

    task automatic if_op(input logic [15:0] addr);
        exp_t e;
        bus.if_req = 1'b1; bus.if_addr = addr;
        e.err = addr[0];
        e.chk_data = !addr[0];
        e.data = ref_read(addr);
        exp_i.push_back(e);
        wait_done(1'b0);
        step();
        bus.if_req = 1'b0;
    endtask

    task automatic wait_mem_req();
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.mem_req) return;
        end
        check("mem_req_timeout", 0, 1);
    endtask

    initial begin
        int          st;
        int          lat;
        int          if_act;
        int unsigned mc0;
        string       exp_order;

        rst_n = 1'b0;
        bus.if_req = 0; bus.if_addr = '0; bus.dm_req = 0; bus.dm_wr = 0;
        bus.dm_addr = '0; bus.dm_wdata = '0; bus.halt = 0;
        bus.mem_ack = 0; bus.mem_rdata = '0;
        fork
            responder();
            monitor();
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_bus", {bus.mem_req, bus.mem_wr, bus.mem_addr, bus.mem_wdata}, 0);
        check("rst_rdata", {bus.if_rdata, bus.dm_rdata}, 0);
        check("rst_flags", {bus.if_done, bus.if_err, bus.dm_done, bus.dm_err, bus.halted}, 0);
        check("rst_stalls", {bus.if_stall, bus.dm_stall}, 0);
        step();
        rst_n = 1'b1;
        step();

        // Single aligned load, ack three cycles after mem_req
        phys_mem[32'h0010] = 16'hBEEF;
        ref_mem[32'h0010]  = 16'hBEEF;
        ack_delay = 3;
        st = 0; lat = -1; if_act = 0;
        fork
            dm_op(1'b0, 16'h0010, 16'h0000);
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (bus.dm_stall) st++;
                if (bus.dm_done && lat < 0) lat = i;
                if (bus.if_done || bus.if_stall || bus.if_err) if_act++;
            end
        join
        check("load_stall_cycles", st, 4);
        check("load_latency", lat, 4);
        check("load_if_quiet", if_act, 0);
`ifdef ARB_PERF_CNT_EN
        check("perf_dm_stall_cnt", dm_stall_cnt, 4);
        check("perf_if_stall_cnt", if_stall_cnt, 0);
`endif

        // Misaligned store never reaches memory
        ack_delay = -1;
        mc0 = mem_cycles;
        dm_op(1'b1, 16'h0003, 16'h1234);
        repeat (2) step();
        check("misaligned_no_mem_req", mem_cycles - mc0, 0);
        check("misaligned_mem_untouched", 32'(phys_mem.exists(32'h0002) || phys_mem.exists(32'h0003)), 0);

        // Tie: IF held back-to-back against back-to-back DM loads
        ack_delay = 0;
        done_log.delete();
        fork
            begin
                if_op(16'h8000);
                if_op(16'h8002);
            end
            for (int i = 0; i < 10; i++) dm_op(1'b0, 16'(16'h0040 + 2 * i), 16'h0000);
        join
        exp_order = "DDDDIDDDDIDD";
        check("tie_done_count", done_log.size(), exp_order.len());
        for (int i = 0; i < exp_order.len() && i < done_log.size(); i++)
            check($sformatf("tie_order_%0d", i), 32'(done_log[i]), 32'(exp_order[i]));
`ifdef ARB_PERF_CNT_EN
        check("perf_starve_evt_cnt", starve_evt_cnt, 2);
`endif
        step();

        // Halt while a fetch is in service
        ack_delay = 3;
        fork
            if_op(16'h8100);
            begin
                wait_mem_req();
                step();
                bus.halt = 1'b1;
                dm_start(1'b0, 16'h0050, 16'h0000);
                wait_done(1'b0);
                @(negedge clk);
                check("halt_not_yet_halted", bus.halted, 0);
                check("halt_no_grant_idle", bus.mem_req, 0);
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    check("halted_high", bus.halted, 1);
                    check("halt_no_grant", {bus.mem_req, bus.dm_done}, 0);
                end
                step();
                bus.halt = 1'b0;
                @(negedge clk);
                check("unhalt_still_idle", bus.mem_req, 0);
                @(negedge clk);
                check("unhalt_dm_granted", {bus.mem_req, bus.mem_wr, bus.mem_addr}, {2'b10, 16'h0050});
                check("unhalt_halted_low", bus.halted, 0);
                dm_finish();
            end
        join

        // Reset in the middle of a data transaction
        ack_delay = 10;
        step();
        bus.dm_req = 1'b1; bus.dm_wr = 1'b0; bus.dm_addr = 16'h0020;
        wait_mem_req();
        step();
        rst_n = 1'b0;
        bus.dm_req = 1'b0;
        @(negedge clk);
        check("rst_mid_no_done", bus.dm_done, 0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid_mem_idle", {bus.mem_req, bus.mem_wr, bus.mem_addr, bus.mem_wdata}, 0);
        check("rst_mid_outputs", {bus.dm_done, bus.dm_err, bus.if_done, bus.halted, bus.dm_rdata, bus.if_rdata}, 0);
        ack_delay = -1;
        step();
        dm_op(1'b0, 16'h0020, 16'h0000);

        // Randomized mixed traffic
        fork
            for (int i = 0; i < 40; i++) begin
                logic [15:0] a;
                repeat ($urandom_range(0, 3)) step();
                a = 16'(16'h8000 + 2 * $urandom_range(0, 255));
                if ($urandom_range(0, 9) == 0) a[0] = 1'b1;
                if_op(a);
            end
            for (int i = 0; i < 40; i++) begin
                logic [15:0] a;
                repeat ($urandom_range(0, 3)) step();
                a = 16'(16'h0040 + 2 * $urandom_range(0, 7));
                if ($urandom_range(0, 9) == 0) a[0] = 1'b1;
                dm_op(1'(($urandom_range(0, 1))), a, 16'($urandom));
            end
        join
        repeat (3) step();
        check("scoreboard_dm_empty", exp_d.size(), 0);
        check("scoreboard_if_empty", exp_i.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
